mem_port_arbiter: RTL

//  Shares the single unified instruction/data memory of the multicycle RISC-V core

---
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of the unified instruction/data memory.
// Port 0 is the core controller, port 1 the DMA/loader; one access in flight at a time.
module mem_port_arbiter #(
    parameter int AW     = 32,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_done,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam logic [3:0] CNT_INIT = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t        r_state, w_next;
    logic          r_last, r_port, r_we, r_err;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_cnt;

    logic          w_any, w_win, w_grant, w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // A lone requester wins outright; a tie goes to the port that did not win last.
    assign w_any   = p0_req | p1_req;
    assign w_win   = (p0_req & p1_req) ? ~r_last : p1_req;
    assign w_grant = reset & (r_state == IDLE) & w_any;
    assign w_we    = w_win ? p1_we    : p0_we;
    assign w_addr  = w_win ? p1_addr  : p0_addr;
    assign w_wdata = w_win ? p1_wdata : p0_wdata;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_next = (w_addr[1:0] == 2'b00) ? ACCESS : DONE;
            ACCESS:  w_next = (r_we || RD_LAT == 1) ? DONE : WAIT;
            WAIT:    if (r_cnt == 4'd1) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_last  <= w_win;
                r_port  <= w_win;
                r_we    <= w_we;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_err   <= (w_addr[1:0] != 2'b00);
            end
            if (r_state == ACCESS)
                r_cnt <= CNT_INIT;
            else if (r_state == WAIT)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    assign p0_gnt    = w_grant & ~w_win;
    assign p1_gnt    = w_grant & w_win;
    assign p0_done   = (r_state == DONE) & ~r_port;
    assign p1_done   = (r_state == DONE) & r_port;
    // Misaligned reads never touch memory, so their data is forced to zero.
    assign rdata     = (r_state == DONE && !r_we && !r_err) ? mem_rdata : '0;
    assign err       = (r_state == DONE) & r_err;
    assign busy      = (r_state != IDLE);
    assign mem_en    = (r_state == ACCESS);
    assign mem_we    = (r_state == ACCESS) & r_we;
    assign mem_addr  = (r_state == ACCESS) ? r_addr  : '0;
    assign mem_wdata = (r_state == ACCESS) ? r_wdata : '0;

endmodule
